// File: rtl/tickgen_pkg.sv
// Shared definitions for the multi-channel tick generator.
//   CLK_HZ        system clock frequency (clk_100MHz)
//   cnt_t         default-width period/counter type
//   hz_to_period  converts a tick rate in Hz to clock cycles per period
//   PERIOD_1HZ / PERIOD_2HZ  legacy traffic-light timebases
//   MIN_PERIOD    shortest period that still produces a distinct tick and square wave
package tickgen_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int          CNT_W_DEFAULT = 27;
  localparam int          MIN_PERIOD    = 2;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  function automatic cnt_t hz_to_period(input int unsigned hz);
    return cnt_t'(CLK_HZ / hz);
  endfunction

  localparam cnt_t PERIOD_1HZ = hz_to_period(1);
  localparam cnt_t PERIOD_2HZ = hz_to_period(2);

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: wrapping counter, registered one-cycle tick and
// registered square wave. With TICKGEN_RUNTIME_CFG_EN defined the channel keeps
// a shadow period that is loaded into the active period at the next wrap.
// Ports:
//   clk_100MHz  system clock
//   reset       asynchronous, active-high
//   en          run enable (low freezes counter and square wave, tick forced 0)
//   sync_clr    synchronous clear; reloads active period from shadow
//   wr          validated period write for this channel
//   wr_period   period value carried with wr
//   tick        one-cycle pulse per period
//   sq          square wave, low for the first floor(P/2) counts
module tick_channel
  import tickgen_pkg::*;
#(
  parameter int              CNT_W  = 27,
  parameter logic [CNT_W-1:0] PERIOD = CNT_W'(MIN_PERIOD)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             tick_d, sq_d;
  logic             wrap;

  assign wrap = en && (cnt_q == active_q - CNT_W'(1));

`ifdef TICKGEN_RUNTIME_CFG_EN
  logic [CNT_W-1:0] shadow_q, shadow_d;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      active_q <= PERIOD;
      shadow_q <= PERIOD;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  // A write landing on the wrap cycle bypasses the shadow so the new
  // period starts with the period that begins at this wrap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (sync_clr) begin
      active_d = shadow_q;
    end else begin
      if (wr) shadow_d = wr_period;
      if (wrap) active_d = wr ? wr_period : shadow_q;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr, wr_period};
  assign active_q  = PERIOD;
  assign active_d  = PERIOD;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q_hold();
    if (sync_clr) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap;
      // Odd periods keep sq high one cycle longer than low.
      sq_d   = (cnt_d >= (active_d >> 1));
    end
  end

  function automatic logic sq_q_hold();
    return sq;
  endfunction

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
      sq    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= tick_d;
      sq    <= sq_d;
    end
  end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel timebase for the traffic-light controller. Each channel emits a
// one-cycle tick enable and a registered square wave in the clk_100MHz domain.
// Optional feature macro: TICKGEN_RUNTIME_CFG_EN enables run-time period
// rewrites (shadow periods, cfg_err). Without it periods are fixed to
// PERIOD_INIT, the cfg inputs are ignored and cfg_err is tied low.
// Ports:
//   clk_100MHz  system clock
//   reset       asynchronous, active-high
//   en          run enable for all channels
//   sync_clr    synchronous clear of all channels
//   cfg_we      period write strobe
//   cfg_ch      target channel of the write
//   cfg_period  new period in clock cycles (>= 2)
//   cfg_err     one-cycle pulse after a rejected write
//   tick        per-channel one-cycle tick
//   sq          per-channel square wave
module tick_generator
  import tickgen_pkg::*;
#(
  parameter int                    N_CH        = 2,
  parameter int                    CNT_W       = 27,
  parameter logic [N_CH*CNT_W-1:0] PERIOD_INIT = {PERIOD_2HZ, PERIOD_1HZ}
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  cfg_we,
  input  logic [$clog2(N_CH):0] cfg_ch,
  input  logic [CNT_W-1:0]      cfg_period,
  output logic                  cfg_err,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       sq
);

  localparam int CH_W = $clog2(N_CH) + 1;

  logic [N_CH-1:0] wr_ch;

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("tick_generator: N_CH must be 1..8");
  end

`ifdef TICKGEN_RUNTIME_CFG_EN
  logic cfg_ok;

  assign cfg_ok = cfg_we && (cfg_ch < CH_W'(N_CH)) &&
                  (cfg_period >= CNT_W'(MIN_PERIOD));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_wr
    assign wr_ch[i] = cfg_ok && (cfg_ch == CH_W'(i));
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_ch};
  assign cfg_err    = 1'b0;
  assign wr_ch      = '0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (PERIOD_INIT[i*CNT_W +: CNT_W] < CNT_W'(MIN_PERIOD)) begin : g_bad_period
      $error("tick_generator: PERIOD_INIT entry below minimum period");
    end

    tick_channel #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .en         (en),
      .sync_clr   (sync_clr),
      .wr         (wr_ch[i]),
      .wr_period  (cfg_period),
      .tick       (tick[i]),
      .sq         (sq[i])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator with two short channels (periods 5 and 4).
// Reference model tracks, per channel, the position inside the current period
// and the active/pending period length; expected outputs are queued each cycle.
module tb_tick_generator;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 8;
  localparam int INIT_P0 = 4;
  localparam int INIT_P1 = 5;
  localparam logic [N_CH*CNT_W-1:0] P_INIT = {8'(INIT_P1), 8'(INIT_P0)};

  logic             clk_100MHz;
  logic             reset;
  logic             en;
  logic             sync_clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_err;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;

  int total = 0;
  int bad   = 0;

  // expected word: {cfg_err, sq[1:0], tick[1:0]}
  logic [4:0] exp_q[$];
  int pos[N_CH];
  int act[N_CH];
  int shd[N_CH];

  tick_generator #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .PERIOD_INIT (P_INIT)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (en),
    .sync_clr   (sync_clr),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .tick       (tick),
    .sq         (sq)
  );

  // clock / reset block
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    act[0] = INIT_P0;
    act[1] = INIT_P1;
    for (int i = 0; i < N_CH; i++) begin
      pos[i] = 0;
      shd[i] = act[i];
    end
    exp_q.delete();
  endtask

  // One clock of the reference: positions advance on enabled cycles and a
  // period ends when its position reaches the period length.
  task automatic model_clock();
    logic [N_CH-1:0] t;
    logic [N_CH-1:0] s;
    logic            e;
    bit              legal;
    legal = cfg_we && (int'(cfg_ch) < N_CH) && (int'(cfg_period) >= 2);
`ifdef TICKGEN_RUNTIME_CFG_EN
    e = cfg_we && !legal;
`else
    e     = 1'b0;
    legal = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      t[i] = 1'b0;
      if (sync_clr) begin
        pos[i] = 0;
        act[i] = shd[i];
      end else begin
        if (legal && int'(cfg_ch) == i) shd[i] = int'(cfg_period);
        if (en) begin
          pos[i]++;
          if (pos[i] == act[i]) begin
            pos[i] = 0;
            t[i]   = 1'b1;
            act[i] = shd[i];
          end
        end
      end
      s[i] = (pos[i] >= act[i] / 2);
    end
    exp_q.push_back({e, s, t});
  endtask

  // driver tasks
  task automatic set_in(input logic e, input logic c, input logic we,
                        input logic [1:0] ch, input logic [CNT_W-1:0] p);
    en = e; sync_clr = c; cfg_we = we; cfg_ch = ch; cfg_period = p;
  endtask

  task automatic step(input string tag);
    logic [4:0] e;
    model_clock();
    @(posedge clk_100MHz);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_tick"}, 32'(tick), 32'(e[1:0]));
      check({tag, "_sq"}, 32'(sq), 32'(e[3:2]));
      check({tag, "_err"}, 32'(cfg_err), 32'(e[4]));
    end
  endtask

  // Fixed-period pattern straight after reset release: tick every P cycles,
  // sq low for the first floor(P/2) positions.
  task automatic start_pattern(input string tag);
    for (int c = 1; c <= 12; c++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
      step(tag);
      check({tag, "_p_tick0"}, 32'(tick[0]), 32'(c % 4 == 0));
      check({tag, "_p_tick1"}, 32'(tick[1]), 32'(c % 5 == 0));
      check({tag, "_p_sq0"}, 32'(sq[0]), 32'((c % 4) >= 2));
      check({tag, "_p_sq1"}, 32'(sq[1]), 32'((c % 5) >= 2));
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_tick0"}, 32'(tick), 32'(0));
    check({tag, "_sq0"}, 32'(sq), 32'(0));
    check({tag, "_err0"}, 32'(cfg_err), 32'(0));
    model_reset();
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk_100MHz);
    #1;
    check("reset_tick", 32'(tick), 32'(0));
    check("reset_sq", 32'(sq), 32'(0));
    check("reset_err", 32'(cfg_err), 32'(0));
    reset = 1'b0;

    start_pattern("start");

    // freeze three cycles mid-period, then resume
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("pre_freeze");
    repeat (3) begin
      set_in(1'b0, 1'b0, 1'b0, 2'd0, 8'd0); step("freeze");
      check("freeze_notick", 32'(tick), 32'(0));
    end
    repeat (10) begin
      set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("resume");
    end

    // synchronous clear, next ch0 tick four cycles later
    set_in(1'b1, 1'b1, 1'b0, 2'd0, 8'd0); step("clr");
    check("clr_out", 32'({sq, tick}), 32'(0));
    for (int c = 1; c <= 4; c++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("post_clr");
      check("post_clr_tick0", 32'(tick[0]), 32'(c == 4));
    end

    // runtime writes: legal, illegal channel, illegal period, on-wrap
    set_in(1'b1, 1'b0, 1'b1, 2'd0, 8'd6); step("wr_p6");
    repeat (14) begin set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("run_p6"); end
    set_in(1'b1, 1'b0, 1'b1, 2'd2, 8'd3); step("bad_ch");
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("bad_ch_after");
    set_in(1'b1, 1'b0, 1'b1, 2'd1, 8'd1); step("bad_p");
    repeat (8) begin set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("bad_p_after"); end
    for (int k = 0; k < 8; k++) begin
      // write on every pos so one of them coincides with a wrap
      set_in(1'b1, 1'b0, 1'b1, 2'd1, 8'(3 + (k % 2))); step("wr_wrap");
    end

    // randomized phase
    for (int n = 0; n < 800; n++) begin
      set_in($urandom_range(0, 9) != 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 9) == 0,
             2'($urandom_range(0, 3)),
             8'($urandom_range(0, 9)));
      step("rand");
    end

    // reset after runtime writes restores the elaboration periods
    set_in(1'b1, 1'b0, 1'b1, 2'd0, 8'd7); step("wr_before_rst");
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 8'd0); step("cnt_before_rst");
    async_reset("midrst");
    start_pattern("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
